// File: rtl/io_bridge_pkg.sv
// Shared constants for the MMIO I/O bridge: register offsets, CTRL/STATUS bit
// positions and field widths.
package io_bridge_pkg;

  localparam int OFF_WIDTH = 3;

  typedef enum logic [OFF_WIDTH-1:0] {
    REG_LED       = 3'd0,
    REG_SW        = 3'd1,
    REG_BTN       = 3'd2,
    REG_BTN_EVT   = 3'd3,
    REG_CYCLE     = 3'd4,
    REG_TIMER_CMP = 3'd5,
    REG_CTRL      = 3'd6,
    REG_STATUS    = 3'd7
  } reg_off_e;

  localparam int CTRL_TIMER_EN_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT   = 1;
  localparam int CTRL_WIDTH        = 2;
  localparam int STATUS_MATCH_BIT  = 0;
  localparam int STATUS_WIDTH      = 1;

  // Member order follows CTRL_IRQ_EN_BIT / CTRL_TIMER_EN_BIT (MSB first).
  typedef struct packed {
    logic irq_en;
    logic timer_en;
  } ctrl_t;

endpackage

// File: rtl/io_debounce.sv
// Per-input conditioner: two-flop synchroniser, followed by a stability filter
// when IO_DEBOUNCE_EN is defined; otherwise the synchronised level passes through.
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  logic meta;
  logic sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  logic             last;
  logic [CNT_W-1:0] cnt;
  logic             level_q;

  // cnt holds how many consecutive equal samples of 'last' have been seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last    <= 1'b0;
      cnt     <= '0;
      level_q <= 1'b0;
    end else if (sync != last) begin
      last <= sync;
      cnt  <= CNT_W'(1);
    end else if (cnt != CNT_DONE) begin
      cnt <= cnt + 1'b1;
    end else begin
      level_q <= last;
    end
  end

  assign level = level_q;
`else
  assign level = sync;
`endif

endmodule

// File: rtl/mmio_io_bridge.sv
// Memory-mapped bridge to LEDs, switches, buttons and a cycle timer with interrupt.
// Define IO_DEBOUNCE_EN to enable the input debounce filters.
module mmio_io_bridge
  import io_bridge_pkg::*;
#(
  parameter int WORD_SIZE       = 32,
  parameter int ADDR_SIZE       = 10,
  parameter int NUM_LEDS        = 4,
  parameter int NUM_SW          = 4,
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  output logic                 rsp_err,
  input  logic [NUM_SW-1:0]    sw_i,
  input  logic [NUM_BTN-1:0]   btn_i,
  output logic [NUM_LEDS-1:0]  led_o,
  output logic                 irq_o
);

  logic [NUM_SW-1:0]    sw_lvl;
  logic [NUM_BTN-1:0]   btn_lvl;
  logic [NUM_BTN-1:0]   btn_prev;
  logic [NUM_BTN-1:0]   btn_evt;
  logic [NUM_LEDS-1:0]  led_q;
  logic [WORD_SIZE-1:0] cycle_q;
  logic [WORD_SIZE-1:0] timer_cmp_q;
  ctrl_t                ctrl_q;
  logic                 match_pend;

  reg_off_e             off;
  logic                 mapped;
  logic                 wr_en;
  logic [NUM_BTN-1:0]   btn_evt_clr;
  logic                 match_clr;
  logic                 match_set;
  logic [WORD_SIZE-1:0] rd_mux;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (sw_i[i]),
      .level (sw_lvl[i])
    );
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_i[i]),
      .level (btn_lvl[i])
    );
  end

  // Only the low offset bits select a register; any upper address bit set is unmapped.
  assign off         = reg_off_e'(req_addr[OFF_WIDTH-1:0]);
  assign mapped      = (req_addr >> OFF_WIDTH) == '0;
  assign wr_en       = req_valid && req_we && mapped;
  assign btn_evt_clr = (wr_en && off == REG_BTN_EVT) ? req_wdata[NUM_BTN-1:0] : '0;
  assign match_clr   = wr_en && (off == REG_STATUS) && req_wdata[STATUS_MATCH_BIT];
  assign match_set   = ctrl_q.timer_en && (cycle_q == timer_cmp_q);

  always_comb begin
    rd_mux = '0;
    case (off)
      REG_LED:       rd_mux = WORD_SIZE'(led_q);
      REG_SW:        rd_mux = WORD_SIZE'(sw_lvl);
      REG_BTN:       rd_mux = WORD_SIZE'(btn_lvl);
      REG_BTN_EVT:   rd_mux = WORD_SIZE'(btn_evt);
      REG_CYCLE:     rd_mux = cycle_q;
      REG_TIMER_CMP: rd_mux = timer_cmp_q;
      REG_CTRL:      rd_mux = WORD_SIZE'(ctrl_q);
      REG_STATUS:    rd_mux = WORD_SIZE'(match_pend);
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= req_valid;
      rsp_err   <= req_valid && !mapped;
      rsp_rdata <= (req_valid && !req_we && mapped) ? rd_mux : '0;
    end
  end

  // Hardware set terms are OR-ed after the W1C mask so a coincident set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q       <= '0;
      cycle_q     <= '0;
      timer_cmp_q <= '0;
      ctrl_q      <= '0;
      match_pend  <= 1'b0;
      btn_prev    <= '0;
      btn_evt     <= '0;
    end else begin
      cycle_q    <= cycle_q + 1'b1;
      btn_prev   <= btn_lvl;
      btn_evt    <= (btn_evt & ~btn_evt_clr) | (btn_lvl & ~btn_prev);
      match_pend <= (match_pend && !match_clr) || match_set;
      if (wr_en && off == REG_LED)       led_q       <= req_wdata[NUM_LEDS-1:0];
      if (wr_en && off == REG_TIMER_CMP) timer_cmp_q <= req_wdata;
      if (wr_en && off == REG_CTRL)      ctrl_q      <= ctrl_t'(req_wdata[CTRL_WIDTH-1:0]);
    end
  end

  assign led_o = led_q;
  assign irq_o = match_pend && ctrl_q.irq_en;

endmodule

// File: doc/mmio_io_bridge.md
MMIO_IO_BRIDGE -- requirements
Module: mmio_io_bridge

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 32, meaning data bus and register width.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 10, meaning word-address width.
REQ-003 The block SHALL have parameter NUM_LEDS, default 4, meaning LED output count (1..WORD_SIZE).
REQ-004 The block SHALL have parameter NUM_SW, default 4, meaning switch input count (1..WORD_SIZE).
REQ-005 The block SHALL have parameter NUM_BTN, default 4, meaning button input count (1..WORD_SIZE).
REQ-006 The block SHALL have parameter DEBOUNCE_CYCLES, default 100000, meaning cycles an input must hold stable before acceptance.
REQ-007 Ports SHALL be: clk  in  1  system clock; rst_n  in  1  reset.
REQ-008 Ports SHALL be: req_valid  in  1  access request; req_we  in  1  write when 1; req_addr  in  ADDR_SIZE  word address; req_wdata  in  WORD_SIZE  write data.
REQ-009 Ports SHALL be: rsp_valid  out  1  response strobe; rsp_rdata  out  WORD_SIZE  read data; rsp_err  out  1  unmapped access.
REQ-010 Ports SHALL be: sw_i  in  NUM_SW  raw switches; btn_i  in  NUM_BTN  raw buttons; led_o  out  NUM_LEDS  LED drive; irq_o  out  1  timer interrupt.
REQ-011 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-012 Every request SHALL be accepted in the cycle req_valid=1; rsp_valid SHALL assert exactly one cycle later for one cycle.
REQ-013 Register map (word offset): 0 LED RW; 1 SW RO; 2 BTN level RO; 3 BTN_EVT W1C; 4 CYCLE RO; 5 TIMER_CMP RW; 6 CTRL RW (bit0 timer_en, bit1 irq_en); 7 STATUS W1C (bit0 match_pend).
REQ-014 Offsets 8 and above SHALL return rdata 0 with rsp_err=1 and have no side effect.
REQ-015 Unused upper bits SHALL read 0; writes to RO registers SHALL be ignored without error.
REQ-016 sw_i and btn_i SHALL each pass through a two-flop synchroniser before any use.
REQ-017 BTN_EVT bit n SHALL set on a 0->1 transition of the accepted button level n and stay set until written 1.
REQ-018 When a hardware set and a W1C clear hit the same bit in the same cycle, set SHALL win.
REQ-019 CYCLE SHALL increment every cycle, wrapping from all-ones to 0.
REQ-020 match_pend SHALL set in the cycle after CYCLE equals TIMER_CMP while timer_en=1, including the wrap case; set wins over clear.
REQ-021 irq_o SHALL equal match_pend AND irq_en, registered-free combinational from flops.
REQ-022 led_o SHALL equal LED[NUM_LEDS-1:0] directly.

Reset
REQ-023 On rst_n low: LED, BTN_EVT, CYCLE, TIMER_CMP, CTRL, STATUS, debounce state, synchroniser flops, rsp_valid, rsp_rdata, rsp_err SHALL be 0; irq_o SHALL be 0.
REQ-024 A request in flight at reset SHALL be dropped with no response.

Configuration
REQ-025 With IO_DEBOUNCE_EN defined, each synchronised input SHALL be accepted only after DEBOUNCE_CYCLES consecutive equal samples, counter restarting on any change.
REQ-026 Without IO_DEBOUNCE_EN, the synchroniser output SHALL be the accepted level directly (2-cycle input latency).

Structure
REQ-027 Register offsets, CTRL/STATUS bit positions and width constants SHALL live in shared package io_bridge_pkg.
REQ-028 The per-input filter SHALL be sub-module io_debounce, instantiated once per switch and button.

Verification
REQ-029 Reset, then read offset 4 twice 3 cycles apart -> values differ by 3, rsp_err=0.
REQ-030 Write LED=0xA, read back -> led_o=4'hA, rdata=0x0000000A.
REQ-031 DEBOUNCE_CYCLES=8, btn_i[0] 0->1 glitching 3 cycles then stable -> BTN_EVT=0x1 only after 2+8 stable cycles; write 0x1 to offset 3 -> reads 0x0.
REQ-032 TIMER_CMP=CYCLE+20, CTRL=0x3 -> irq_o=1 at match+1; W1C STATUS coinciding with a new match -> match_pend stays 1.
REQ-033 Read offset 9 -> rdata=0, rsp_err=1; write offset 1 -> SW unchanged, rsp_err=0.
REQ-034 Assert rst_n low mid-request -> no rsp_valid, all outputs 0 within same cycle.
